// File: rtl/picosoc_busarb.sv
`default_nettype none
// ============================================================================
// Module   : picosoc_busarb
// Purpose  : Round-robin two-master arbiter for the picorv32 native bus with
//            a watchdog that force-completes accesses no slave answers.
// Revision : 1.0 - initial release
// ============================================================================
module picosoc_busarb #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hFFFF_FFFF,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        err_irq,
    output logic [31:0] err_addr,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_TOUT = 2'd2
    } state_t;

    localparam bit              C_WDOG_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] C_TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic               err_irq_q, err_irq_d;
    logic [31:0]        err_addr_q, err_addr_d;
    logic [7:0]         err_count_q, err_count_d;

    logic               w_gnt_valid;
    logic               w_gnt_instr;
    logic [31:0]        w_gnt_addr;
    logic [31:0]        w_gnt_wdata;
    logic [3:0]         w_gnt_wstrb;
    logic               w_s_valid;
    logic               w_gnt_ready;
    logic [31:0]        w_gnt_rdata;

    assign w_gnt_valid = grant_q ? m1_valid : m0_valid;
    assign w_gnt_instr = grant_q ? m1_instr : m0_instr;
    assign w_gnt_addr  = grant_q ? m1_addr  : m0_addr;
    assign w_gnt_wdata = grant_q ? m1_wdata : m0_wdata;
    assign w_gnt_wstrb = grant_q ? m1_wstrb : m0_wstrb;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        timer_d     = timer_q;
        err_irq_d   = 1'b0;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        w_s_valid   = 1'b0;
        w_gnt_ready = 1'b0;
        w_gnt_rdata = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (m0_valid || m1_valid) begin
                    // On a tie the master that did not finish last wins.
                    grant_d = (m0_valid && m1_valid) ? ~last_q : m1_valid;
                    state_d = ST_BUSY;
                    timer_d = '0;
                end
            end
            ST_BUSY: begin
                w_s_valid   = w_gnt_valid;
                w_gnt_ready = s_ready;
                w_gnt_rdata = s_rdata;
                if (s_ready) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end else if (!w_gnt_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (C_WDOG_EN && (timer_q == C_TIMER_LAST)) begin
                        state_d   = ST_TOUT;
                        err_irq_d = 1'b1;
                    end
                end
            end
            ST_TOUT: begin
                w_gnt_ready = 1'b1;
                w_gnt_rdata = TIMEOUT_DATA;
                state_d     = ST_IDLE;
                last_d      = grant_q;
                err_addr_d  = w_gnt_addr;
                if (err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            timer_q     <= '0;
            err_irq_q   <= 1'b0;
            err_addr_q  <= 32'h0;
            err_count_q <= 8'h0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            timer_q     <= timer_d;
            err_irq_q   <= err_irq_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    // Handshake outputs are masked by reset so an abandoned access never completes.
    assign s_valid  = w_s_valid & ~reset;
    assign s_instr  = w_gnt_instr;
    assign s_addr   = w_gnt_addr;
    assign s_wdata  = w_gnt_wdata;
    assign s_wstrb  = w_gnt_wstrb;

    assign m0_ready = w_gnt_ready & ~grant_q & ~reset;
    assign m1_ready = w_gnt_ready &  grant_q & ~reset;
    assign m0_rdata = grant_q ? 32'h0 : w_gnt_rdata;
    assign m1_rdata = grant_q ? w_gnt_rdata : 32'h0;

    assign err_irq   = err_irq_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_picosoc_busarb.sv
`default_nettype none
// ============================================================================
// Module   : tb_picosoc_busarb
// Purpose  : Directed scoreboard bench for the two-master bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_picosoc_busarb;

    localparam int unsigned C_TOUT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        err_irq;
    logic [31:0] err_addr;
    logic [7:0]  err_count;

    typedef struct {
        logic        m;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          done0    = 0;
    int          done1    = 0;
    int          scnt     = 0;
    int          sdelay   = 0;
    int          nsteps   = 0;
    logic        got0     = 1'b0;
    logic        got1     = 1'b0;
    logic [31:0] skey     = 32'h1234_5668;

    picosoc_busarb #(
        .TIMEOUT_CYCLES (C_TOUT),
        .TIMEOUT_DATA   (32'hFFFF_FFFF),
        .CNT_W          (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_valid  (m0_valid),
        .m0_instr  (m0_instr),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_wstrb  (m0_wstrb),
        .m0_ready  (m0_ready),
        .m0_rdata  (m0_rdata),
        .m1_valid  (m1_valid),
        .m1_instr  (m1_instr),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_wstrb  (m1_wstrb),
        .m1_ready  (m1_ready),
        .m1_rdata  (m1_rdata),
        .s_valid   (s_valid),
        .s_instr   (s_instr),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_ready   (s_ready),
        .s_rdata   (s_rdata),
        .err_irq   (err_irq),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: release completed masters, answer as the slave, then check outputs.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (got0) begin m0_valid = 1'b0; got0 = 1'b0; end
        if (got1) begin m1_valid = 1'b0; got1 = 1'b0; end
        #2;
        if (!s_valid) begin
            s_ready = 1'b0;
            scnt    = 0;
        end else begin
            s_ready = (sdelay >= 0) && (scnt == sdelay);
            scnt++;
        end
        s_rdata = s_ready ? (s_addr ^ skey) : 32'h0;
        #2;
        if (s_valid && sb.size() > 0) begin
            e = sb[0];
            check("pass_addr",  s_addr,             e.m ? m1_addr  : m0_addr);
            check("pass_wdata", s_wdata,            e.m ? m1_wdata : m0_wdata);
            check("pass_wstrb", 32'(s_wstrb),       32'(e.m ? m1_wstrb : m0_wstrb));
            check("pass_instr", 32'(s_instr),       32'(e.m ? m1_instr : m0_instr));
        end
        if (m0_ready || m1_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'(m0_ready | m1_ready), 32'd0);
            end else begin
                e = sb.pop_front();
                check("ready_master", 32'(m1_ready), 32'(e.m));
                check("ready_other",  32'(e.m ? m0_ready : m1_ready), 32'd0);
                check("rdata",        e.m ? m1_rdata : m0_rdata, e.data);
                check("rdata_other",  e.m ? m0_rdata : m1_rdata, 32'h0);
                check("err_irq",      32'(err_irq), 32'(e.err));
                if (e.m) begin got1 = 1'b1; done1++; end
                else     begin got0 = 1'b1; done0++; end
            end
        end else begin
            check("err_irq_quiet", 32'(err_irq), 32'd0);
        end
    endtask

    task automatic issue(input logic m, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic instr);
        if (m) begin
            m1_valid = 1'b1; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb; m1_instr = instr;
        end else begin
            m0_valid = 1'b1; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb; m0_instr = instr;
        end
    endtask

    task automatic expect_tx(input logic m, input logic [31:0] data, input logic err);
        exp_t e;
        e.m = m; e.data = data; e.err = err;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int t0, input int t1, output int n);
        n = 0;
        while ((done0 < t0 || done1 < t1) && n < 60) begin
            step();
            n++;
        end
        check("wait_budget", 32'(done0 >= t0 && done1 >= t1), 32'd1);
        step();
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset = 1'b1;
        m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
        m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
        s_ready = 1'b0; s_rdata = 32'h0;
        step(); step();
        reset = 1'b0;
        step();
        check("rst_s_valid",   32'(s_valid),   32'd0);
        check("rst_m0_ready",  32'(m0_ready),  32'd0);
        check("rst_m1_ready",  32'(m1_ready),  32'd0);
        check("rst_err_addr",  err_addr,       32'h0);
        check("rst_err_count", 32'(err_count), 32'd0);

        // Tie out of reset: master 0 first, then master 1.
        sdelay = 1;
        issue(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b1);
        issue(1'b1, 32'h0000_0200, 32'h0, 4'h0, 1'b0);
        expect_tx(1'b0, 32'h0000_0100 ^ skey, 1'b0);
        expect_tx(1'b1, 32'h0000_0200 ^ skey, 1'b0);
        wait_done(done0 + 1, done1 + 1, nsteps);

        // Single master read, slave answers on its third cycle.
        sdelay = 2;
        check("idle_s_valid", 32'(s_valid), 32'd0);
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b1);
        expect_tx(1'b0, 32'h1234_5678, 1'b0);
        wait_done(done0 + 1, done1, nsteps);
        check("single_latency", 32'(nsteps), 32'd3);

        // Master 0 finished last, so the next tie goes to master 1.
        sdelay = 1;
        issue(1'b0, 32'h0000_0104, 32'h0, 4'h0, 1'b0);
        issue(1'b1, 32'h0000_0204, 32'h0, 4'h0, 1'b0);
        expect_tx(1'b1, 32'h0000_0204 ^ skey, 1'b0);
        expect_tx(1'b0, 32'h0000_0104 ^ skey, 1'b0);
        wait_done(done0 + 1, done1 + 1, nsteps);
        issue(1'b0, 32'h0000_0108, 32'h0, 4'h0, 1'b0);
        issue(1'b1, 32'h0000_0208, 32'h0, 4'h0, 1'b0);
        expect_tx(1'b1, 32'h0000_0208 ^ skey, 1'b0);
        expect_tx(1'b0, 32'h0000_0108 ^ skey, 1'b0);
        wait_done(done0 + 1, done1 + 1, nsteps);

        // Master 1 partial write passes through unchanged.
        issue(1'b1, 32'h0200_0008, 32'hCAFE_BABE, 4'b0011, 1'b0);
        expect_tx(1'b1, 32'h0200_0008 ^ skey, 1'b0);
        wait_done(done0, done1 + 1, nsteps);
        check("write_latency", 32'(nsteps), 32'd2);

        // Unmapped read: forced completion with error data.
        sdelay = -1;
        issue(1'b0, 32'h0300_0000, 32'h0, 4'h0, 1'b0);
        expect_tx(1'b0, 32'hFFFF_FFFF, 1'b1);
        wait_done(done0 + 1, done1, nsteps);
        check("tout_latency", 32'(nsteps), 32'(C_TOUT + 1));
        check("tout_err_addr",  err_addr,       32'h0300_0000);
        check("tout_err_count", 32'(err_count), 32'd1);

        // Slave answers on the last allowed cycle: normal completion wins.
        sdelay = int'(C_TOUT) - 1;
        issue(1'b0, 32'h0300_0004, 32'h0, 4'h0, 1'b0);
        expect_tx(1'b0, 32'h0300_0004 ^ skey, 1'b0);
        wait_done(done0 + 1, done1, nsteps);
        check("race_latency",   32'(nsteps),    32'(C_TOUT));
        check("race_err_count", 32'(err_count), 32'd1);
        check("race_err_addr",  err_addr,       32'h0300_0000);

        // 255 more timeouts, alternating masters; the counter must stick at 255.
        sdelay = -1;
        for (int i = 0; i < 255; i++) begin
            issue(i[0], 32'h0400_0000 + 32'(i * 4), 32'h0, 4'h0, 1'b0);
            expect_tx(i[0], 32'hFFFF_FFFF, 1'b1);
            wait_done(done0 + (i[0] ? 0 : 1), done1 + (i[0] ? 1 : 0), nsteps);
            if (i == 253) check("sat_255", 32'(err_count), 32'd255);
        end
        check("sat_hold",     32'(err_count), 32'd255);
        check("sat_err_addr", err_addr,       32'h0400_0000 + 32'(254 * 4));

        // Reset while the slave is being accessed abandons the transfer.
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b0);
        expect_tx(1'b0, 32'h0, 1'b0);
        step(); step(); step();
        check("pre_rst_s_valid", 32'(s_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_s_valid",  32'(s_valid),  32'd0);
        check("midrst_m0_ready", 32'(m0_ready), 32'd0);
        check("midrst_m1_ready", 32'(m1_ready), 32'd0);
        sb.delete();
        m0_valid = 1'b0;
        step(); step();
        reset = 1'b0;
        check("postrst_err_count", 32'(err_count), 32'd0);
        check("postrst_err_addr",  err_addr,       32'h0);

        // After reset master 0 wins the tie again.
        sdelay = 1;
        issue(1'b0, 32'h0000_0110, 32'h0, 4'h0, 1'b0);
        issue(1'b1, 32'h0000_0210, 32'h0, 4'h0, 1'b0);
        expect_tx(1'b0, 32'h0000_0110 ^ skey, 1'b0);
        expect_tx(1'b1, 32'h0000_0210 ^ skey, 1'b0);
        wait_done(done0 + 1, done1 + 1, nsteps);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/picosoc_busarb.md
Name: picosoc_busarb

Overview:
Two-master arbiter for the picorv32 native memory bus (valid/ready/addr/wdata/wstrb/rdata). It shares the single SoC slave fabric (RAM, ROM/spimemio, UART, GPIO decode) between the CPU (master 0) and a DMA/debug master (master 1), using round-robin grant. It adds a bus watchdog: an access to an unmapped address never sees a slave ready, so after a timeout the arbiter completes the access itself, returns error data and flags the fault.

Parameters:
TIMEOUT_CYCLES, 256, number of BUSY cycles without s_ready before a forced completion; 0 disables the watchdog.
TIMEOUT_DATA, 32'hFFFF_FFFF, rdata returned to the master on a forced completion.
CNT_W, 16, timer width; TIMEOUT_CYCLES must be below 2**CNT_W.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m0_valid/m0_instr  in  1/1  master 0 request, instruction-fetch flag
m0_addr/m0_wdata  in  32/32  master 0 address, write data
m0_wstrb  in  4  master 0 byte strobes (0 = read)
m0_ready  out  1  master 0 completion
m0_rdata  out  32  master 0 read data
m1_valid/m1_instr/m1_addr/m1_wdata/m1_wstrb  in  1/1/32/32/4  master 1 request, same as m0
m1_ready/m1_rdata  out  1/32  master 1 completion and read data
s_valid/s_instr  out  1/1  request to slave fabric
s_addr/s_wdata  out  32/32  slave address, write data
s_wstrb  out  4  slave byte strobes
s_ready  in  1  slave completion (OR of all slave readies)
s_rdata  in  32  muxed slave read data
err_irq  out  1  one-cycle pulse on forced completion
err_addr  out  32  address of the last timed-out access
err_count  out  8  saturating count of timeouts

Behaviour:
- States: IDLE, BUSY, TOUT. Registers: grant (1b), last (1b), timer (CNT_W), err_*.
- Reset values: state=IDLE, grant=0, last=1 (master 0 wins the first tie), timer=0, err_irq=0, err_addr=0, err_count=0. While reset is high, s_valid, m0_ready and m1_ready are forced 0 combinationally. Reset asserted mid-transaction abandons the transaction with no ready and no error.
- IDLE: s_valid=0, both m_ready=0.
  - If only mX_valid is set: grant<=X.
  - If both are set: grant<=~last.
  - Any valid: state<=BUSY, timer<=0. Arbitration costs exactly one cycle.
- BUSY:
  - s_valid/s_instr/s_addr/s_wdata/s_wstrb mirror the granted master combinationally.
  - m[grant]_ready = s_ready and m[grant]_rdata = s_rdata. The non-granted master sees ready=0 and rdata=0.
  - On s_ready: state<=IDLE, last<=grant.
  - If the granted master drops valid without ready (protocol violation): state<=IDLE, last unchanged, no error.
  - Otherwise timer<=timer+1. If TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1 and s_ready=0: state<=TOUT.
  - s_ready on that same final cycle wins: normal completion, no error.
- TOUT (one cycle):
  - s_valid=0, m[grant]_ready=1, m[grant]_rdata=TIMEOUT_DATA, err_irq=1.
  - err_addr<=granted addr; err_count<=err_count+1, saturating at 255.
  - state<=IDLE, last<=grant.
  - Writes that time out are dropped; the master sees completion.
- No starvation: a master waiting during another's transfer is granted next, because last flips.
- Non-granted master requests are held pending and never lost; picorv32 keeps valid asserted until ready.
- Latency: slave response time + 1 cycle; a timeout completes TIMEOUT_CYCLES+1 cycles after grant.
- err_irq is registered and is 1 only in the TOUT cycle; it is intended for irq[3] (irq_stall).

Test Plan:
- Single master: m0 reads 0x0000_0010, slave returns ready 2 cycles after s_valid with 0x1234_5678 -> s_valid 1 cycle after m0_valid, m0_ready pulse with rdata 0x1234_5678, m1_ready stays 0.
- Simultaneous requests out of reset: m0 and m1 valid together, slave 1-cycle ready -> m0 served first, then m1; repeated simultaneous requests alternate 0,1,0,1.
- Write pass-through: m1 writes 0xCAFEBABE with wstrb=4'b0011 to 0x0200_0008 -> s_wdata/s_wstrb/s_addr match exactly while BUSY, single m1_ready pulse.
- Timeout: TIMEOUT_CYCLES=8, m0 reads 0x0300_0000, s_ready never asserted -> m0_ready after 9 cycles with 0xFFFF_FFFF, err_irq one cycle, err_addr=0x0300_0000, err_count=1; 256 timeouts -> err_count saturates at 255.
- Race at limit: s_ready arrives exactly on timer==TIMEOUT_CYCLES-1 -> normal completion with slave data, err_irq=0, err_count unchanged.
- Reset mid-BUSY: assert reset while s_valid=1 -> s_valid, m*_ready go 0 immediately; after release, state IDLE, err_count=0, and m0 wins the next tie.
